// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS multiply/divide unit.
// Operation codes and FSM state encodings.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One iteration of the HI/LO datapath: shift-add multiply or
// restoring shift-subtract divide, purely combinational.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] x,
  input  logic [2*WIDTH-1:0] y,
  input  logic [WIDTH-1:0]   z,
  output logic [2*WIDTH-1:0] x_next,
  output logic [2*WIDTH-1:0] y_next,
  output logic [WIDTH-1:0]   z_next
);
  import mips_cpu_pkg::*;

  localparam int W = WIDTH;

  logic [W:0] trial;
  logic [W:0] diff;

  // Divide: x = {remainder, dividend/quotient}, y[W-1:0] = divisor.
  // Multiply: x = accumulator, y = shifted multiplicand, z = multiplier.
  always_comb begin
    trial  = {x[2*W-1:W], x[W-1]};
    diff   = trial - {1'b0, y[W-1:0]};
    x_next = x;
    y_next = y;
    z_next = z;
    if (is_div) begin
      if (!diff[W]) begin
        x_next = {diff[W-1:0], x[W-2:0], 1'b1};
      end else begin
        x_next = {trial[W-1:0], x[W-2:0], 1'b0};
      end
    end else begin
      if (z[0]) begin
        x_next = x + y;
      end
      y_next = y << 1;
      z_next = z >> 1;
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Optional early multiply exit: define MULDIV_EARLY_OUT_EN.
module mips_cpu_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_cpu_pkg::*;

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  muldiv_state_t state;
  muldiv_op_t    op_q;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] x, y, x_next, y_next;
  logic [W-1:0]   z, z_next;
  logic          qneg, rneg, dz, done_q;
  logic [W-1:0]  hi_q, lo_q;

  logic          sgn, is_div_q, early;
  logic [W-1:0]  abs_a, abs_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]  q, r, hi_fix, lo_fix;

  assign sgn      = ~op[0];
  assign abs_a    = (sgn && a[W-1]) ? (-a) : a;
  assign abs_b    = (sgn && b[W-1]) ? (-b) : b;
  assign is_div_q = (op_q == DIV) || (op_q == DIVU);

  mips_cpu_muldiv_step #(.WIDTH(W)) u_step (
    .is_div (is_div_q),
    .x      (x),
    .y      (y),
    .z      (z),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

`ifdef MULDIV_EARLY_OUT_EN
  assign early = !is_div_q && (z_next == '0);
`else
  assign early = 1'b0;
`endif

  // Sign correction applied on the FIX edge.
  always_comb begin
    prod   = qneg ? (-x) : x;
    q      = qneg ? (-x[W-1:0]) : x[W-1:0];
    r      = rneg ? (-x[2*W-1:W]) : x[2*W-1:W];
    hi_fix = prod[2*W-1:W];
    lo_fix = prod[W-1:0];
    if (is_div_q) begin
      hi_fix = r;
      lo_fix = dz ? '1 : q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= MULT;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= muldiv_op_t'(op);
            qneg  <= sgn & (a[W-1] ^ b[W-1]);
            rneg  <= sgn & a[W-1];
            dz    <= (b == '0);
            cnt   <= CW'(WIDTH);
            state <= RUN;
            if (op[1]) begin
              x <= {{W{1'b0}}, abs_a};
              y <= {{W{1'b0}}, abs_b};
              z <= '0;
            end else begin
              x <= '0;
              y <= {{W{1'b0}}, abs_a};
              z <= abs_b;
            end
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        RUN: begin
          x   <= x_next;
          y   <= y_next;
          z   <= z_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1) || early) state <= FIX;
        end
        FIX: begin
          hi_q   <= hi_fix;
          lo_q   <= lo_fix;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Self-checking bench for mips_cpu_muldiv_unit (WIDTH=32).
// Latency-level reference model plus directed literal vectors.
module tb_mips_cpu_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  mips_cpu_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [1:0] o,
                                             input logic [31:0] aa,
                                             input logic [31:0] bb);
    longint sa, sb, p, qq, rr;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    if (o[0]) begin
      sa = longint'({32'b0, aa});
      sb = longint'({32'b0, bb});
    end
    if (!o[1]) begin
      p = sa * sb;
      return p;
    end
    if (bb == 32'b0) return {aa, 32'hFFFF_FFFF};
    qq = sa / sb;
    rr = sa % sb;
    return {rr[31:0], qq[31:0]};
  endfunction

  // Enabled edges from the start edge to the HI/LO write.
  function automatic int ref_latency(input logic [1:0] o,
                                     input logic [31:0] bb);
    int n;
    n = 32;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] mb;
      mb = (o == 2'b00 && bb[31]) ? -bb : bb;
      n = 1;
      for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
    end
`endif
    return n + 1;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  logic [63:0] m_res;
  int          m_rem;

  always @(posedge clk) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem  <= 0;
    end else if (clk_enable) begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
        m_rem <= m_rem - 1;
      end else if (start) begin
        m_res  <= ref_result(op, a, b);
        m_rem  <= ref_latency(op, b);
        m_busy <= 1'b1;
      end else begin
        if (mthi) m_hi <= a;
        if (mtlo) m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 64'(busy), 64'(m_busy));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 64'(n), 64'(budget + 1));
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n;
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, n);
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
    check({nm, "_lat"}, 64'(n), 64'(lat));
    check({nm, "_model"}, {m_hi, m_lo}, {eh, el});
  endtask

  initial begin
    int n, total;
    logic seen;
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0;
    op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    chk_en = 1'b1;

    run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0000_0000, 33);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, 33);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    run_op("div_z", 2'b10, 32'h1234_5678, 32'd0,
           32'h1234_5678, 32'hFFFF_FFFF, 33);
    run_op("div_zneg", 2'b10, 32'hFFFF_FFF0, 32'd0,
           32'hFFFF_FFF0, 32'hFFFF_FFFF, 33);
    run_op("divu_z", 2'b11, 32'h8000_0001, 32'd0,
           32'h8000_0001, 32'hFFFF_FFFF, 33);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 33);
`ifdef MULDIV_EARLY_OUT_EN
    run_op("multu_eo", 2'b01, 32'd5, 32'd3, 32'd0, 32'd15, 3);
`else
    run_op("multu_eo", 2'b01, 32'd5, 32'd3, 32'd0, 32'd15, 33);
`endif

    // Start, mthi and mtlo while busy are all ignored.
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    a = 32'hAAAA_0000; mthi = 1'b1; mtlo = 1'b1;
    start = 1'b1; op = 2'b01; b = 32'd3;
    repeat (3) @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
    check("busy_hold_hi", 64'(hi), 64'd0);
    wait_done(100, n);
    check("busy_mthi_hi", 64'(hi), 64'd2);
    check("busy_mthi_lo", 64'(lo), 64'd14);

    // Moves in IDLE.
    @(posedge clk); #1;
    a = 32'hAAAA_0000; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi_hi", 64'(hi), 64'hAAAA_0000);
    check("mthi_lo", 64'(lo), 64'd14);
    a = 32'h5555_5555; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h5555_5555);
    check("mtlo_hi", 64'(hi), 64'hAAAA_0000);

    // Start beats a simultaneous move.
    mthi = 1'b1; mtlo = 1'b1;
    run_op("start_wins", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 33);
    mthi = 1'b0; mtlo = 1'b0;

    a = 32'h5A5A_5A5A; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check("mtboth_hi", 64'(hi), 64'h5A5A_5A5A);
    check("mtboth_lo", 64'(lo), 64'h5A5A_5A5A);

    // Reset in RUN cycle 10, with clk_enable low to prove priority.
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk); #1;
    reset = 1'b1; clk_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; clk_enable = 1'b1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Five stalled cycles mid-RUN push completion out by five.
    op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk); #1;
    clk_enable = 1'b0;
    repeat (5) @(posedge clk); #1;
    clk_enable = 1'b1;
    wait_done(100, n);
    total = n + 10;
    check("stall_lat", 64'(total), 64'd38);
    check("stall_hi", 64'(hi), 64'hFFFF_FFFE);
    check("stall_lo", 64'(lo), 64'h0000_0001);

    repeat (2) @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
